param_frame_tx: RTL
===================

# param_frame_tx

Transmit-side counterpart of the acceptance-filter parameter loader. Accepts an 11-bit mask, an 11-bit code and a 2-bit SJW value through a valid/ready handshake. Serialises them as a parameter frame: a one-cycle `param_id` strobe followed by three byte beats on an 8-bit bus. Sits in the host/config path and drives the `param_id`/`data` pins of the parameter register block.

## Interface
- `GAP_CYCLES`, default 2: idle cycles inserted after each frame before `ready` reasserts; 0–15 legal.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `valid`  in  1  host request; frame fields are valid while high.
- `mask_in`  in  11  acceptance mask to send.
- `code_in`  in  11  acceptance code to send.
- `sjw_in`  in  2  sync jump width to send.
- `ready`  out  1  high only in IDLE; transfer occurs on an edge with `valid & ready`.
- `param_id`  out  1  frame-start strobe, one cycle per frame.
- `data`  out  8  byte beat.
- `data_valid`  out  1  high on byte-beat cycles only.
- `done`  out  1  one-cycle pulse on final beat of frame.

## Operation
- States: IDLE, ID, B0, B1, B2, PAR (macro only), GAP.
- IDLE: `ready`=1. On `valid`, capture `mask_in`/`code_in`/`sjw_in` into shadow registers and go to ID. Input changes after capture are ignored for that frame.
- ID: `param_id`=1, `data`=8'h00, `data_valid`=0 → B0.
- B0: `data`=mask[7:0] → B1.
- B1: `data`={code[4:0], mask[10:8]} → B2.
- B2: `data`={sjw[1:0], code[10:5]}. Next: PAR if macro defined, else GAP if `GAP_CYCLES`>0, else IDLE.
- PAR: `data`=B0^B1^B2 → GAP/IDLE as above.
- GAP: 4-bit down-counter loaded with `GAP_CYCLES`-1 on entry. Exit to IDLE when it reads 0. All outputs idle.
- `data_valid`=1 in B0, B1, B2, PAR. `done`=1 in last beat state only (B2, or PAR when enabled).
- Outside B0..PAR: `data`=8'h00. `ready`=0 in every state except IDLE. `valid` outside IDLE is ignored, with no queuing.
- All outputs are registered (Moore), glitch-free.

## Timing
- Reset: state IDLE, `ready`=1, `param_id`=0, `data`=8'h00, `data_valid`=0, `done`=0, shadow regs 0, gap counter 0.
- Handshake at edge k. `param_id` high in cycle k+1. B0/B1/B2 in cycles k+2/k+3/k+4. PAR in k+5 if enabled.
- Frame period: 5 + `GAP_CYCLES` cycles (6 + `GAP_CYCLES` with parity) for back-to-back `valid`.
- `GAP_CYCLES`=0: `ready` high in the cycle after the last beat. The next handshake may occur there.
- Reset mid-frame: outputs return to reset values immediately (async). The partial frame is abandoned. No `done`.
- `valid` held high continuously: a new frame starts each time IDLE is entered. Fields are re-sampled at each handshake.
- `valid` dropping in the cycle after the handshake has no effect on the frame in flight.

## Configuration
- `PARAM_TX_PARITY_EN` defined: PAR state is compiled in. A fourth beat carries the XOR of B0..B2, and `done` moves to PAR.
- Undefined: 3-beat frame, `done` on B2, and no PAR state or parity logic is present.

## Test plan
- Reset, then mask=11'h5A3, code=11'h2C7, sjw=2'b10, `valid` 1 cycle → `param_id` pulse, then `data` 8'hA3, 8'h3D, 8'h96 with `data_valid`. `done` on 8'h96. With parity: extra beat 8'h08 carrying `done`.
- mask=11'h7FF, code=11'h7FF, sjw=2'b11 → beats 8'hFF ×3 (parity beat 8'hFF). mask=code=0, sjw=0 → 8'h00 ×3, parity 8'h00.
- `GAP_CYCLES`=2, `valid` held high → `param_id` pulses exactly 7 cycles apart (8 with parity). `GAP_CYCLES`=0 → 5 apart (6 with parity).
- Change `mask_in` to 11'h001 and pulse `valid` during B0 of a frame → current frame still sends 8'hA3/8'h3D/8'h96. `ready` stays low and no extra frame is sent.
- Assert `reset` during B1 → same cycle `data`=0, `data_valid`=0, `ready`=1, no `done`. Next handshake produces a complete correct frame.
- Loopback into the parameter register block → it latches mask 11'h5A3, code 11'h2C7, sjw 2'b10.

Source files
------------

// File: rtl/param_frame_tx.sv
// ---------------------------------------------------------------------------
// param_frame_tx
//
// Purpose : serialises an acceptance-filter parameter set (11-bit mask,
//           11-bit code, 2-bit SJW) into a parameter frame for the parameter
//           register block. A frame is a one-cycle param_id strobe followed by
//           three byte beats (four with parity). After the frame, GAP_CYCLES
//           idle cycles pass before ready reasserts.
//
// Build option : define PARAM_TX_PARITY_EN to add a fourth beat carrying the
//                XOR of the three data beats. done then moves to that beat.
//
// Parameters:
//   GAP_CYCLES   idle cycles after each frame, 0..15 (default 2)
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   valid        in   host request; fields are sampled when valid & ready
//   mask_in      in   [10:0] acceptance mask
//   code_in      in   [10:0] acceptance code
//   sjw_in       in   [1:0]  sync jump width
//   ready        out  high only while IDLE
//   param_id     out  frame-start strobe, one cycle per frame
//   data         out  [7:0] byte beat, 8'h00 outside beat cycles
//   data_valid   out  high on byte-beat cycles
//   done         out  one-cycle pulse on the final beat
//
// All outputs are registered. They are decoded from the next state, so each
// output tracks the state it belongs to without a cycle of lag.
// ---------------------------------------------------------------------------
module param_frame_tx #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [10:0] mask_in,
    input  logic [10:0] code_in,
    input  logic [1:0]  sjw_in,
    output logic        ready,
    output logic        param_id,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        done
);

    localparam int unsigned MASK_W = 11;
    localparam int unsigned CODE_W = 11;
    localparam int unsigned SJW_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    // Counter load value. GAP_CYCLES == 0 never enters GAP, so the load value
    // is unused in that case.
    localparam logic [CNT_W-1:0] GAP_LOAD =
        CNT_W'((GAP_CYCLES > 32'd0) ? (GAP_CYCLES - 32'd1) : 32'd0);
    localparam bit HAS_GAP = (GAP_CYCLES != 32'd0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ID   = 3'd1,
        S_B0   = 3'd2,
        S_B1   = 3'd3,
        S_B2   = 3'd4,
`ifdef PARAM_TX_PARITY_EN
        S_PAR  = 3'd5,
`endif
        S_GAP  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_gap_cnt;
    logic [CNT_W-1:0]    w_gap_cnt_nxt;
    logic                w_capture;

    logic [MASK_W-1:0]   r_mask;
    logic [CODE_W-1:0]   r_code;
    logic [SJW_W-1:0]    r_sjw;

    logic                r_ready;
    logic                r_param_id;
    logic [BYTE_W-1:0]   r_data;
    logic                r_data_valid;
    logic                r_done;

    logic                w_ready_nxt;
    logic                w_param_id_nxt;
    logic [BYTE_W-1:0]   w_data_nxt;
    logic                w_data_valid_nxt;
    logic                w_done_nxt;

    logic [BYTE_W-1:0]   w_byte0;
    logic [BYTE_W-1:0]   w_byte1;
    logic [BYTE_W-1:0]   w_byte2;
`ifdef PARAM_TX_PARITY_EN
    logic [BYTE_W-1:0]   w_byte_par;
`endif

    // Beat payloads, built from the captured shadow copy of the fields.
    assign w_byte0 = r_mask[7:0];
    assign w_byte1 = {r_code[4:0], r_mask[10:8]};
    assign w_byte2 = {r_sjw, r_code[10:5]};
`ifdef PARAM_TX_PARITY_EN
    assign w_byte_par = w_byte0 ^ w_byte1 ^ w_byte2;
`endif

    // State, gap counter and shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_mask    <= '0;
            r_code    <= '0;
            r_sjw     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_capture) begin
                r_mask <= mask_in;
                r_code <= code_in;
                r_sjw  <= sjw_in;
            end
        end
    end

    // Registered outputs, loaded from the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready      <= 1'b1;
            r_param_id   <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_param_id   <= w_param_id_nxt;
            r_data       <= w_data_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state logic and next-state output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_capture        = 1'b0;
        w_ready_nxt      = 1'b0;
        w_param_id_nxt   = 1'b0;
        w_data_nxt       = '0;
        w_data_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ID;
                end
            end
            S_ID: w_state_nxt = S_B0;
            S_B0: w_state_nxt = S_B1;
            S_B1: w_state_nxt = S_B2;
`ifdef PARAM_TX_PARITY_EN
            S_B2: w_state_nxt = S_PAR;
            S_PAR: begin
                if (HAS_GAP) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`else
            S_B2: begin
                if (HAS_GAP) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs belong to the state being entered. Entering B0 always comes
        // from ID, so the shadow registers already hold the captured fields.
        case (w_state_nxt)
            S_IDLE: w_ready_nxt = 1'b1;
            S_ID:   w_param_id_nxt = 1'b1;
            S_B0: begin
                w_data_nxt       = w_byte0;
                w_data_valid_nxt = 1'b1;
            end
            S_B1: begin
                w_data_nxt       = w_byte1;
                w_data_valid_nxt = 1'b1;
            end
`ifdef PARAM_TX_PARITY_EN
            S_B2: begin
                w_data_nxt       = w_byte2;
                w_data_valid_nxt = 1'b1;
            end
            S_PAR: begin
                w_data_nxt       = w_byte_par;
                w_data_valid_nxt = 1'b1;
                w_done_nxt       = 1'b1;
            end
`else
            S_B2: begin
                w_data_nxt       = w_byte2;
                w_data_valid_nxt = 1'b1;
                w_done_nxt       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ready      = r_ready;
    assign param_id   = r_param_id;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign done       = r_done;

endmodule
